// File: rtl/servo_pkg.sv
// Shared widths, FSM phase type and parameter legality check
// for the servo PWM output block.
package servo_pkg;

  localparam int CMD_W   = 10;
  localparam int FRAME_W = 15;
  localparam int WIDTH_W = 12;

  typedef enum logic {
    PH_GAP   = 1'b0,
    PH_PULSE = 1'b1
  } phase_t;

  function automatic bit params_ok(
    input int frame_us,
    input int min_us,
    input int timeout
  );
    return (min_us >= 0)
      && (min_us + 1023 < (1 << WIDTH_W))
      && (frame_us >= min_us + 1024)
      && (frame_us <= 32767)
      && (timeout >= 1)
      && (timeout <= 255);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame position counter in 1 us ticks; flags the
// wrapping tick and marks the cycle after it as frame start.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_US = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1us,
  output logic [FRAME_W-1:0] frame_next,
  output logic               boundary,
  output logic               frame_start
);

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(FRAME_US - 1);

  logic [FRAME_W-1:0] frame_q;
  logic               at_last;

  assign at_last    = (frame_q == LAST);
  assign boundary   = tick_1us && at_last;
  assign frame_next = at_last ? '0 : frame_q + FRAME_W'(1);

  // Parked on the last index so the first tick after reset opens a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= LAST;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick_1us) frame_q <= frame_next;
    end
  end

endmodule

// File: rtl/servo_out.sv
// 50 Hz servo pulse generator with a double-buffered command
// and a frame-count failsafe back to a default position.
module servo_out
  import servo_pkg::*;
#(
  parameter int               FRAME_US       = 20000,
  parameter int               MIN_US         = 988,
  parameter logic [CMD_W-1:0] DEFAULT        = 10'd512,
  parameter int               TIMEOUT_FRAMES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1us,
  input  logic             en,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             pwm,
  output logic             frame_start,
  output logic             stale
);

  if (!params_ok(FRAME_US, MIN_US, TIMEOUT_FRAMES)) begin : g_bad_params
    $error("servo_out: illegal parameter set");
  end

  localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_US);
  localparam logic [7:0]         TO    = 8'(TIMEOUT_FRAMES);

  logic [FRAME_W-1:0] frame_next;
  logic               boundary;
  logic [CMD_W-1:0]   shadow_q;
  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] width_d;
  logic [7:0]         miss_q;
  logic [7:0]         miss_inc;
  logic               in_window;
  logic               pulse_d;
  phase_t             phase_q;

  servo_frame_timer #(
    .FRAME_US (FRAME_US)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .tick_1us    (tick_1us),
    .frame_next  (frame_next),
    .boundary    (boundary),
    .frame_start (frame_start)
  );

  assign width_d   = boundary ? MIN_W + WIDTH_W'(shadow_q) : width_q;
  assign miss_inc  = (miss_q == 8'hff) ? miss_q : miss_q + 8'd1;
  assign in_window = frame_next < FRAME_W'(width_d);

  // A pulse may only begin at a boundary; once dropped it stays low.
  assign pulse_d = en && in_window
    && (boundary || phase_q == PH_PULSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= DEFAULT;
      width_q  <= MIN_W + WIDTH_W'(DEFAULT);
      miss_q   <= '0;
      stale    <= 1'b0;
      phase_q  <= PH_GAP;
      pwm      <= 1'b0;
    end else begin
      width_q <= width_d;
      if (cmd_valid) begin
        shadow_q <= cmd;
        miss_q   <= '0;
        stale    <= 1'b0;
      end else if (boundary) begin
        miss_q <= miss_inc;
        if (miss_inc == TO) begin
          shadow_q <= DEFAULT;
          stale    <= 1'b1;
        end
      end
      if (tick_1us) begin
        phase_q <= pulse_d ? PH_PULSE : PH_GAP;
        pwm     <= pulse_d;
      end
    end
  end

endmodule
